alu_exec: RTL and testbench

Execute-stage ALU unit for the pipelined CPU. Consumes the 4-bit ALU control code from the ALU control decoder together with two 32-bit operands. Produces result, zero and overflow flags through a two-stage valid/ready pipeline (ID/EX capture, EX/MEM result register). Supports back-pressure from the memory stage and a branch-mispredict flush.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_core.sv | 54 +++++
 rtl/alu_exec.sv | 100 ++++++++++
 tb/tb_alu_exec.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU control decoder and the execute-stage
// ALU. It holds the control-code width and the ALU operation encodings.
package alu_pkg;

  localparam int CTRL_W = 4;

  // 4-bit ALU control codes produced by the ALU control decoder.
  typedef enum logic [CTRL_W-1:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0100,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU datapath.
// Ports:
//   ctrl_i    - ALU control code
//   a_i, b_i  - operands
//   result_o  - ALU result (0 for undefined codes)
//   ovf_o     - signed overflow, ADD/SUB only
//   illegal_o - ctrl_i is not a defined code
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              ovf_o,
  output logic              illegal_o
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] sum, diff;
  logic              slt;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;
  // Direct signed compare, not the sign of diff, so SLT stays right when
  // a - b overflows.
  assign slt  = $signed(a_i) < $signed(b_i);

  always_comb begin
    result_o  = '0;
    ovf_o     = 1'b0;
    illegal_o = 1'b0;
    case (ctrl_i)
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_NOR: result_o = ~(a_i | b_i);
      ALU_ADD: begin
        result_o = sum;
        ovf_o    = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
      end
      ALU_SUB: begin
        result_o = diff;
        ovf_o    = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
      end
      ALU_SLT: result_o = {{(DATA_W-1){1'b0}}, slt};
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with a two-stage valid/ready pipeline.
// S1 captures the operand bundle and S2 registers the result and flags.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   in_valid/in_ready     - operand handshake (in_ctrl, in_a, in_b, in_tag)
//   flush                 - kills everything in flight on the next edge
//   out_valid/out_ready   - result handshake
//   out_result/out_zero/out_ovf/out_illegal/out_tag - registered result bundle
module alu_exec
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [4:0]        in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_ovf,
  output logic              out_illegal,
  output logic [4:0]        out_tag
);

  logic s1_v, s2_v;
  logic [CTRL_W-1:0] s1_ctrl_q;
  logic [DATA_W-1:0] s1_a_q, s1_b_q;
  logic [4:0]        s1_tag_q;

  logic s2_adv, s1_load, s2_load;
  logic [DATA_W-1:0] core_result;
  logic              core_ovf, core_illegal;

  // s2_adv is the raw advance condition and drives in_ready even during a
  // flush; the actual register loads are gated by flush.
  assign s2_adv   = s1_v & (~s2_v | out_ready);
  assign in_ready = ~s1_v | s2_adv;
  assign s1_load  = in_valid & in_ready & ~flush;
  assign s2_load  = s2_adv & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else if (flush) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      s1_v <= s1_load | (s1_v & ~s2_adv);
      s2_v <= s2_adv | (s2_v & ~out_ready);
    end
  end

  // S1 operand capture; data needs no reset because s1_v qualifies it.
  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_ctrl_q <= in_ctrl;
      s1_a_q    <= in_a;
      s1_b_q    <= in_b;
      s1_tag_q  <= in_tag;
    end
  end

  alu_core #(.DATA_W(DATA_W)) u_core (
    .ctrl_i    (s1_ctrl_q),
    .a_i       (s1_a_q),
    .b_i       (s1_b_q),
    .result_o  (core_result),
    .ovf_o     (core_ovf),
    .illegal_o (core_illegal)
  );

  // S2 result register. It only loads on advance, so the outputs hold
  // while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_ovf     <= 1'b0;
      out_illegal <= 1'b0;
      out_tag     <= '0;
    end else if (s2_load) begin
      out_result  <= core_result;
      out_zero    <= (core_result == '0);
      out_ovf     <= core_ovf;
      out_illegal <= core_illegal;
      out_tag     <= s1_tag_q;
    end
  end

  assign out_valid = s2_v;

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_ctrl = '0;
  logic [31:0] in_a = '0, in_b = '0;
  logic [4:0]  in_tag = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_zero, out_ovf, out_illegal;
  logic [4:0]  out_tag;

  alu_exec #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_ovf(out_ovf),
    .out_illegal(out_illegal), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        ill;
    logic [4:0]  tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: arithmetic on wide signed integers, overflow is
  // "true result does not fit in 32 signed bits".
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] t);
    exp_t e;
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.res = 32'd0; e.ovf = 1'b0; e.ill = 1'b0; e.tag = t;
    case (c)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0100: e.res = a ^ b;
      4'b1100: e.res = ~(a | b);
      4'b0010: begin
        s = sa + sb; e.res = 32'(s);
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        s = sa - sb; e.res = 32'(s);
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // One clock cycle of stimulus; starts and returns 1 time unit after a posedge.
  // ov/ir report out_valid/in_ready sampled mid-cycle.
  task automatic step(input logic v, input logic [3:0] c, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] t, input logic fl,
                      input logic ordy, output logic ov, output logic ir);
    logic acc;
    in_valid = v; in_ctrl = c; in_a = a; in_b = b; in_tag = t;
    flush = fl; out_ready = ordy;
    @(negedge clk);
    ov = out_valid;
    ir = in_ready;
    acc = in_valid && in_ready && !flush;
    @(posedge clk);
    if (fl) q.delete();
    else if (acc) q.push_back(model(c, a, b, t));
    #1;
  endtask

  task automatic drain();
    logic ov, ir;
    for (int i = 0; i < 20 && q.size() != 0; i++)
      step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, ov, ir);
    step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, ov, ir);
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
  endtask

  // Monitor: pops and compares on every output handshake, and checks that
  // a stalled result holds steady.
  exp_t held;
  logic hold = 1'b0;
  initial begin
    exp_t e, act;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        act = '{out_result, out_zero, out_ovf, out_illegal, out_tag};
        if (hold && out_valid) chk("stall_stable", 32'(act), 32'(held));
        hold = 1'b0;
        if (out_valid) begin
          if (out_ready) begin
            if (q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_out: got tag %0d result %h expected no output", out_tag, out_result);
            end else begin
              e = q.pop_front();
              chk("out_result", out_result, e.res);
              chk("out_zero", 32'(out_zero), 32'(e.zero));
              chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
              chk("out_illegal", 32'(out_illegal), 32'(e.ill));
              chk("out_tag", 32'(out_tag), 32'(e.tag));
            end
          end else begin
            hold = 1'b1;
            held = act;
          end
        end
      end
    end
  end

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic ov, ir;
    logic [3:0] codes [9];
    codes = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'h4, 4'hF, 4'h3};

    // Reset state
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_out_illegal", 32'(out_illegal), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD overflow and latency
    step(1'b1, 4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd7, 1'b0, 1'b1, ov, ir);
    chk("add_accept", 32'(ir), 32'd1);
    step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, ov, ir);
    chk("add_latency_not_early", 32'(ov), 32'd0);
    chk("add_latency_valid", 32'(out_valid), 32'd1);
    chk("add_ovf_result", out_result, 32'h8000_0000);
    chk("add_ovf_flag", 32'(out_ovf), 32'd1);
    chk("add_ovf_zero", 32'(out_zero), 32'd0);
    drain();

    // SUB to zero, signed SLT, NOR, illegal code
    step(1'b1, 4'b0110, 32'd5, 32'd5, 5'd1, 1'b0, 1'b1, ov, ir);
    step(1'b1, 4'b0111, 32'h8000_0000, 32'd1, 5'd2, 1'b0, 1'b1, ov, ir);
    step(1'b1, 4'b1100, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1, ov, ir);
    step(1'b1, 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 5'd4, 1'b0, 1'b1, ov, ir);
    drain();

    // Back-to-back with stall
    step(1'b1, 4'b0010, 32'd10, 32'd1, 5'd1, 1'b0, 1'b0, ov, ir);
    chk("b2b_accept1", 32'(ir), 32'd1);
    step(1'b1, 4'b0010, 32'd20, 32'd2, 5'd2, 1'b0, 1'b0, ov, ir);
    chk("b2b_accept2", 32'(ir), 32'd1);
    step(1'b1, 4'b0010, 32'd30, 32'd3, 5'd3, 1'b0, 1'b0, ov, ir);
    chk("b2b_full_in_ready", 32'(ir), 32'd0);
    chk("b2b_hold_tag1", 32'(out_tag), 32'd1);
    step(1'b1, 4'b0010, 32'd30, 32'd3, 5'd3, 1'b0, 1'b0, ov, ir);
    chk("b2b_still_full", 32'(ir), 32'd0);
    chk("b2b_hold_tag1b", 32'(out_tag), 32'd1);
    step(1'b1, 4'b0010, 32'd30, 32'd3, 5'd3, 1'b0, 1'b1, ov, ir);
    chk("b2b_release_in_ready", 32'(ir), 32'd1);
    drain();

    // Flush with both stages valid while offering tag 9
    step(1'b1, 4'b0001, 32'hF0, 32'h0F, 5'd4, 1'b0, 1'b0, ov, ir);
    step(1'b1, 4'b0001, 32'hF0, 32'h0F, 5'd5, 1'b0, 1'b0, ov, ir);
    step(1'b1, 4'b0000, 32'hFF, 32'hFF, 5'd9, 1'b1, 1'b0, ov, ir);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, ov, ir);
    chk("flush_no_tag9", 32'(ov), 32'd0);
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : codes[$urandom_range(0, 8)],
           rnd_opnd(), rnd_opnd(), 5'($urandom),
           $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0, ov, ir);
    end
    drain();

    // Asynchronous reset mid-stream
    step(1'b1, 4'b0010, 32'd1, 32'd2, 5'd10, 1'b0, 1'b1, ov, ir);
    step(1'b1, 4'b0010, 32'd3, 32'd4, 5'd11, 1'b0, 1'b0, ov, ir);
    step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, ov, ir);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_out_tag", 32'(out_tag), 32'd0);
    q.delete();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, ov, ir);
    chk("post_reset_idle", 32'(ov), 32'd0);
    step(1'b1, 4'b0100, 32'hAAAA_5555, 32'hFFFF_0000, 5'd12, 1'b0, 1'b1, ov, ir);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
